w5500_xfer_ctrl: RTL and testbench

- Transaction sequencer directly upstream of the W5500 SPI byte driver.
- Accepts register/buffer access requests (block select, offset, length, direction) and buffers write payload bytes in an internal FIFO.
- Issues one start pulse with the W5500 control byte, address and length to the driver. Feeds payload bytes on the driver's data request and collects read bytes into an output stream with a last marker.
- Sits between the socket/command logic and the SPI driver.

---
 rtl/w5500_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/w5500_xfer_ctrl.sv | 147 ++++++++++++++
 tb/tb_w5500_xfer_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w5500_pkg.sv
// Shared definitions for the W5500 transaction sequencer: FSM state codes,
// control-byte field values and block-select helpers.
package w5500_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CHECK = 3'd1;
  localparam state_t ST_FILL  = 3'd2;
  localparam state_t ST_START = 3'd3;
  localparam state_t ST_RUN   = 3'd4;
  localparam state_t ST_FIN   = 3'd5;

  // Variable-length data mode in the control byte.
  localparam logic [1:0] OM_VDM = 2'b00;

  localparam logic RWB_WRITE = 1'b1;
  localparam logic RWB_READ  = 1'b0;

  localparam logic [4:0] BSB_COMMON = 5'b00000;

  function automatic logic [4:0] bsb_sock_reg(input logic [2:0] n);
    return {n, 2'b01};
  endfunction

  function automatic logic [4:0] bsb_sock_tx(input logic [2:0] n);
    return {n, 2'b10};
  endfunction

  function automatic logic [4:0] bsb_sock_rx(input logic [2:0] n);
    return {n, 2'b11};
  endfunction

  // Control byte = {block select, read/write bit, operating mode}.
  function automatic logic [7:0] make_cmd(input logic [4:0] bsb, input logic rwb);
    return {bsb, rwb, OM_VDM};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with show-ahead output and occupancy count.
// Push when full and pop when empty are silently ignored.
module sync_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/w5500_xfer_ctrl.sv
// W5500 transaction sequencer: validates a request, waits for write payload,
// launches the SPI byte driver, feeds write bytes and forwards read bytes.
// Handshake: a request transfers on a cycle where req_vld && req_rdy; a
// payload byte transfers on a cycle where wd_vld && wd_rdy. rd_vld, done,
// err and spi_start are single-cycle pulses with no back-pressure.
module w5500_xfer_ctrl
  import w5500_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_LEN    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_wr,
  input  logic [4:0]  req_bsb,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_len,
  input  logic        wd_vld,
  input  logic [7:0]  wd_dat,
  output logic        wd_rdy,
  output logic        rd_vld,
  output logic [7:0]  rd_dat,
  output logic        rd_last,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        spi_start,
  output logic [7:0]  spi_cmd,
  output logic [15:0] spi_addr,
  output logic [15:0] spi_len,
  output logic [7:0]  spi_dat,
  input  logic        spi_dat_req,
  input  logic        spi_rd_vld,
  input  logic [7:0]  spi_rd_dat,
  input  logic        spi_end
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t      state;
  state_t      state_nxt;
  logic        wr_q;
  logic [4:0]  bsb_q;
  logic [15:0] addr_q;
  logic [15:0] len_q;
  logic [15:0] pop_cnt;
  logic [15:0] rx_cnt;
  logic [AW:0] fifo_cnt;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        accept;
  logic        len_bad;
  logic        fill_ok;
  logic        pop;
  logic        rx_take;

  assign accept  = req_vld && (state == ST_IDLE);
  assign len_bad = (len_q == 16'd0) || (len_q > MAX_LEN_W);
  assign fill_ok = (16'(fifo_cnt) >= len_q);
  assign pop     = (state == ST_RUN) && wr_q && spi_dat_req && (pop_cnt < len_q);
  assign rx_take = (state == ST_RUN) && !wr_q && spi_rd_vld && (rx_cnt < len_q);

  assign req_rdy   = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign spi_start = (state == ST_START);
  assign done      = (state == ST_FIN);
  assign err       = (state == ST_CHECK) && len_bad;
  assign wd_rdy    = !fifo_full;

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wd_vld),
    .din   (wd_dat),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  // Next-state decode for the transaction sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_CHECK;
      ST_CHECK: if (len_bad)   state_nxt = ST_IDLE;
                else if (wr_q) state_nxt = ST_FILL;
                else           state_nxt = ST_START;
      ST_FILL:  if (fill_ok) state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN:   if (spi_end) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, request latch, driver fields and data-path registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_q     <= 1'b0;
      bsb_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      pop_cnt  <= '0;
      rx_cnt   <= '0;
      spi_cmd  <= '0;
      spi_addr <= '0;
      spi_len  <= '0;
      spi_dat  <= '0;
      rd_vld   <= 1'b0;
      rd_dat   <= '0;
      rd_last  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_vld <= 1'b0;
      if (accept) begin
        wr_q    <= req_wr;
        bsb_q   <= req_bsb;
        addr_q  <= req_addr;
        len_q   <= req_len;
        pop_cnt <= '0;
        rx_cnt  <= '0;
      end
      // Driver fields are loaded on entry to START and held until next request.
      if (state_nxt == ST_START && state != ST_START) begin
        spi_cmd  <= make_cmd(bsb_q, wr_q ? RWB_WRITE : RWB_READ);
        spi_addr <= addr_q;
        spi_len  <= len_q;
      end
      if (pop) begin
        spi_dat <= fifo_dout;
        pop_cnt <= pop_cnt + 16'd1;
      end
      if (rx_take) begin
        rx_cnt  <= rx_cnt + 16'd1;
        rd_vld  <= 1'b1;
        rd_dat  <= spi_rd_dat;
        rd_last <= (rx_cnt + 16'd1 == len_q);
      end
    end
  end

endmodule

// File: tb/tb_w5500_xfer_ctrl.sv
// Directed bench for w5500_xfer_ctrl: a scripted SPI driver model feeds
// requests/ends and compares outputs at the falling edge.
module tb_w5500_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_wr = 1'b0;
  logic [4:0]  req_bsb = '0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        wd_vld = 1'b0;
  logic [7:0]  wd_dat = '0;
  logic        wd_rdy;
  logic        rd_vld;
  logic [7:0]  rd_dat;
  logic        rd_last;
  logic        done;
  logic        err;
  logic        busy;
  logic        spi_start;
  logic [7:0]  spi_cmd;
  logic [15:0] spi_addr;
  logic [15:0] spi_len;
  logic [7:0]  spi_dat;
  logic        spi_dat_req = 1'b0;
  logic        spi_rd_vld = 1'b0;
  logic [7:0]  spi_rd_dat = '0;
  logic        spi_end = 1'b0;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  w5500_xfer_ctrl #(.FIFO_DEPTH(64), .MAX_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_bsb(req_bsb),
    .req_addr(req_addr), .req_len(req_len),
    .wd_vld(wd_vld), .wd_dat(wd_dat), .wd_rdy(wd_rdy),
    .rd_vld(rd_vld), .rd_dat(rd_dat), .rd_last(rd_last),
    .done(done), .err(err), .busy(busy),
    .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_addr(spi_addr), .spi_len(spi_len),
    .spi_dat(spi_dat), .spi_dat_req(spi_dat_req),
    .spi_rd_vld(spi_rd_vld), .spi_rd_dat(spi_rd_dat), .spi_end(spi_end)
  );

  // Clock and pulse monitors.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spi_start) start_cnt <= start_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wd_vld = 1'b1;
    wd_dat = b;
    tick();
    wd_vld = 1'b0;
  endtask

  task automatic send_req(input logic wr, input logic [4:0] bsb,
                          input logic [15:0] addr, input logic [15:0] len);
    int n = 0;
    while (!req_rdy && n < 50) begin tick(); n++; end
    req_vld = 1'b1; req_wr = wr; req_bsb = bsb; req_addr = addr; req_len = len;
    tick();
    req_vld = 1'b0;
  endtask

  // Wait for spi_start, confirm it lasts one cycle; returns in RUN.
  task automatic wait_start(input string name);
    int n = 0;
    while (!spi_start && n < 100) begin tick(); n++; end
    checks++;
    if (spi_start !== 1'b1) begin
      errors++;
      $display("FAIL %s start_timeout got=%b want=1", name, spi_start);
    end
    tick();
    checks++;
    if (spi_start !== 1'b0) begin
      errors++;
      $display("FAIL %s start_width got=%b want=0", name, spi_start);
    end
  endtask

  // Driver model for write payload: request, check spi_dat 8 cycles later.
  task automatic run_wr_driver(input string name, input int n, input int extra);
    logic [7:0] exp_b = '0;
    for (int i = 0; i < n + extra; i++) begin
      spi_dat_req = 1'b1;
      tick();
      spi_dat_req = 1'b0;
      repeat (7) tick();
      if (i < n) exp_b = exp_q.pop_front();
      checks++;
      if (spi_dat !== exp_b) begin
        errors++;
        $display("FAIL %s spi_dat[%0d] got=%h want=%h", name, i, spi_dat, exp_b);
      end
    end
    spi_end = 1'b1;
    tick();
    spi_end = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done got=%b want=1", name, done);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({req_rdy, wd_rdy, busy, spi_start, done, err, rd_vld, rd_last} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=11000000",
               {req_rdy, wd_rdy, busy, spi_start, done, err, rd_vld, rd_last});
    end
    checks++;
    if ({spi_cmd, spi_addr, spi_len, spi_dat, rd_dat} !== 56'd0) begin
      errors++;
      $display("FAIL reset_fields got=%h want=0", {spi_cmd, spi_addr, spi_len, spi_dat, rd_dat});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write4();
    int d0 = done_cnt;
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    send_req(1'b1, 5'b00000, 16'h0001, 16'd4);
    wait_start("wr4");
    checks++;
    if ({spi_cmd, spi_addr, spi_len} !== {8'h04, 16'h0001, 16'd4}) begin
      errors++;
      $display("FAIL wr4_fields got=%h/%h/%h want=04/0001/0004", spi_cmd, spi_addr, spi_len);
    end
    // One surplus request must pop nothing: spi_dat holds 0x44.
    run_wr_driver("wr4", 4, 1);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL wr4_done_count got=%0d want=1", done_cnt - d0);
    end
    checks++;
    if (dut.u_fifo.count !== 7'd0) begin
      errors++;
      $display("FAIL wr4_fifo_empty got=%0d want=0", dut.u_fifo.count);
    end
  endtask

  task automatic test_read2();
    // Prefill one byte for the next test; the read must not pop it.
    push_byte(8'hA5);
    send_req(1'b0, 5'b00001, 16'h0003, 16'd2);
    wait_start("rd2");
    checks++;
    if ({spi_cmd, spi_addr, spi_len} !== {8'h08, 16'h0003, 16'd2}) begin
      errors++;
      $display("FAIL rd2_fields got=%h/%h/%h want=08/0003/0002", spi_cmd, spi_addr, spi_len);
    end
    spi_dat_req = 1'b1;
    tick();
    spi_dat_req = 1'b0;
    tick();
    checks++;
    if (dut.u_fifo.count !== 7'd1) begin
      errors++;
      $display("FAIL rd2_no_pop got=%0d want=1", dut.u_fifo.count);
    end
    spi_rd_vld = 1'b1; spi_rd_dat = 8'h42;
    tick();
    spi_rd_vld = 1'b0;
    checks++;
    if ({rd_vld, rd_dat, rd_last} !== {1'b1, 8'h42, 1'b0}) begin
      errors++;
      $display("FAIL rd2_byte0 got=%b/%h/%b want=1/42/0", rd_vld, rd_dat, rd_last);
    end
    tick();
    checks++;
    if (rd_vld !== 1'b0) begin
      errors++;
      $display("FAIL rd2_pulse got=%b want=0", rd_vld);
    end
    spi_rd_vld = 1'b1; spi_rd_dat = 8'h5A;
    tick();
    spi_rd_vld = 1'b0;
    checks++;
    if ({rd_vld, rd_dat, rd_last} !== {1'b1, 8'h5A, 1'b1}) begin
      errors++;
      $display("FAIL rd2_byte1 got=%b/%h/%b want=1/5a/1", rd_vld, rd_dat, rd_last);
    end
    // Surplus byte beyond len is dropped.
    spi_rd_vld = 1'b1; spi_rd_dat = 8'h77;
    tick();
    spi_rd_vld = 1'b0;
    checks++;
    if (rd_vld !== 1'b0) begin
      errors++;
      $display("FAIL rd2_drop got=%b want=0", rd_vld);
    end
    spi_end = 1'b1;
    tick();
    spi_end = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rd2_done got=%b want=1", done);
    end
    tick();
  endtask

  task automatic test_late_data();
    int s0 = start_cnt;
    exp_q = {8'hA5, 8'hB6, 8'hC7};
    send_req(1'b1, 5'b00010, 16'h0010, 16'd3);
    repeat (6) tick();
    checks++;
    if (busy !== 1'b1 || start_cnt != s0) begin
      errors++;
      $display("FAIL late_fill_wait got busy=%b starts=%0d want busy=1 starts=0", busy, start_cnt - s0);
    end
    push_byte(8'hB6);
    push_byte(8'hC7);
    checks++;
    if (spi_start !== 1'b0) begin
      errors++;
      $display("FAIL late_start_early got=%b want=0", spi_start);
    end
    tick();
    checks++;
    if (spi_start !== 1'b1) begin
      errors++;
      $display("FAIL late_start_2cyc got=%b want=1", spi_start);
    end
    wait_start("late");
    checks++;
    if (spi_cmd !== 8'h14) begin
      errors++;
      $display("FAIL late_cmd got=%h want=14", spi_cmd);
    end
    run_wr_driver("late", 3, 0);
  endtask

  task automatic test_illegal_len();
    int s0 = start_cnt;
    logic [15:0] lens [2];
    lens[0] = 16'd0;
    lens[1] = 16'd65;
    for (int i = 0; i < 2; i++) begin
      send_req(i[0], 5'b00001, 16'h0000, lens[i]);
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL illegal_err[%0d] got=%b want=1", i, err);
      end
      tick();
      checks++;
      if ({err, req_rdy, busy} !== 3'b010) begin
        errors++;
        $display("FAIL illegal_idle[%0d] got=%b want=010", i, {err, req_rdy, busy});
      end
    end
    repeat (3) tick();
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL illegal_no_start got=%0d want=0", start_cnt - s0);
    end
  endtask

  task automatic test_fifo_bounds();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (wd_rdy !== 1'b1) begin
        errors++;
        $display("FAIL fifo_rdy[%0d] got=%b want=1", i, wd_rdy);
      end
      push_byte(8'(i * 5 + 3));
      exp_q.push_back(8'(i * 5 + 3));
    end
    checks++;
    if (wd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full got=%b want=0", wd_rdy);
    end
    send_req(1'b1, 5'b00110, 16'h0200, 16'd64);
    wait_start("fifo1");
    // Push and pop in the same cycle while full: the push is refused.
    spi_dat_req = 1'b1; wd_vld = 1'b1; wd_dat = 8'hEE;
    tick();
    spi_dat_req = 1'b0; wd_vld = 1'b0;
    checks++;
    if (dut.u_fifo.count !== 7'd63) begin
      errors++;
      $display("FAIL fifo_full_pushpop got=%0d want=63", dut.u_fifo.count);
    end
    repeat (7) tick();
    checks++;
    if (spi_dat !== exp_q[0]) begin
      errors++;
      $display("FAIL fifo1 spi_dat[0] got=%h want=%h", spi_dat, exp_q[0]);
    end
    void'(exp_q.pop_front());
    run_wr_driver("fifo1", 63, 0);
    for (int i = 0; i < 64; i++) begin
      push_byte(8'(255 - i));
      exp_q.push_back(8'(255 - i));
    end
    send_req(1'b1, 5'b00110, 16'h0240, 16'd64);
    wait_start("fifo2");
    run_wr_driver("fifo2", 64, 0);
    checks++;
    if (dut.u_fifo.count !== 7'd0 || wd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL fifo2_empty got=%0d/%b want=0/1", dut.u_fifo.count, wd_rdy);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0 = done_cnt;
    push_byte(8'h31); push_byte(8'h32);
    send_req(1'b1, 5'b00000, 16'h0100, 16'd2);
    wait_start("rst");
    spi_dat_req = 1'b1;
    tick();
    spi_dat_req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({req_rdy, wd_rdy, busy, spi_start, done, err, rd_vld} !== 7'b1100000) begin
      errors++;
      $display("FAIL rst_flags got=%b want=1100000", {req_rdy, wd_rdy, busy, spi_start, done, err, rd_vld});
    end
    checks++;
    if ({spi_cmd, spi_addr, spi_len, spi_dat} !== 48'd0 || dut.u_fifo.count !== 7'd0) begin
      errors++;
      $display("FAIL rst_fields got=%h cnt=%0d want=0 cnt=0", {spi_cmd, spi_addr, spi_len, spi_dat}, dut.u_fifo.count);
    end
    // Stale end from the aborted driver transfer is ignored.
    spi_end = 1'b1;
    tick();
    spi_end = 1'b0;
    tick();
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done got=%0d busy=%b want=0 busy=0", done_cnt - d0, busy);
    end
    exp_q = {8'h99};
    push_byte(8'h99);
    send_req(1'b1, 5'b00000, 16'h0002, 16'd1);
    wait_start("rst_next");
    run_wr_driver("rst_next", 1, 0);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL rst_next_done got=%0d want=1", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_write4();
    test_read2();
    test_late_data();
    test_illegal_len();
    test_fifo_bounds();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
